// File: rtl/spi_master_gen.sv
// spi_master_gen: single-clock SPI master with run-time CPOL/CPHA, bit order and chip-select choice.
// Build macro SPI_MASTER_GEN_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
//
// state | meaning
// IDLE  | waiting for start; cs_n all high, mosi low, sclk follows cpol input
// SETUP | chip select asserted, DIV cycles before the first sclk edge
// XFER  | 2*DATA_W sclk edges, one every DIV cycles
// HOLD  | chip select still asserted, DIV cycles after the last edge
module spi_master_gen #(
    parameter int DATA_W = 16,
    parameter int DIV    = 4,
    parameter int NCS    = 2,
    localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CSW-1:0]    cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              miso,
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    output logic [NCS-1:0]    cs_n
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam int IW = EW - 1;
    localparam logic [TW-1:0] TICK_LOAD = TW'(DIV - 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NCS-1:0]    cs_n_q, cs_n_d;

    logic [NCS-1:0]    cs_dec;
    logic              sample_in;
    logic              tick_tc;
    logic [IW-1:0]     bit_idx;

    // Maps the n-th bit on the wire to its position in the data word.
    function automatic logic [IW-1:0] bit_pos(input logic [IW-1:0] idx, input logic lsb);
        return lsb ? idx : (IW'(DATA_W - 1) - idx);
    endfunction

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
    assign sample_in = loopback ? mosi_q : miso;
`else
    assign sample_in = miso;
`endif

    assign tick_tc = (tick_q == '0);
    assign bit_idx = edge_q[EW-1:1];

    // An out-of-range cs_sel matches no bit, so every select stays high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NCS; i++) begin
            if (cs_sel == CSW'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;

        unique case (state_q)
            IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                cs_n_d = '1;
                busy_d = 1'b0;
                if (start) begin
                    state_d = SETUP;
                    tick_d  = TICK_LOAD;
                    edge_d  = '0;
                    tx_d    = tx_data;
                    rx_sh_d = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    busy_d  = 1'b1;
                    cs_n_d  = cs_dec;
                    mosi_d  = cpha ? 1'b0 : tx_data[bit_pos(IW'(0), lsb_first)];
                end
            end

            SETUP: begin
                if (tick_tc) begin
                    state_d = XFER;
                    tick_d  = TICK_LOAD;
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end

            XFER: begin
                if (tick_tc) begin
                    tick_d = TICK_LOAD;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (!edge_q[0]) begin
                        // Leading edge
                        if (cpha_q) begin
                            mosi_d = tx_q[bit_pos(bit_idx, lsb_q)];
                        end else begin
                            rx_sh_d[bit_pos(bit_idx, lsb_q)] = sample_in;
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_sh_d[bit_pos(bit_idx, lsb_q)] = sample_in;
                        end else if (edge_q != LAST_EDGE) begin
                            mosi_d = tx_q[bit_pos(bit_idx + IW'(1), lsb_q)];
                        end
                        if (edge_q == LAST_EDGE) begin
                            state_d = HOLD;
                        end
                    end
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end

            HOLD: begin
                if (tick_tc) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    cs_n_d    = '1;
                    mosi_d    = 1'b0;
                    sclk_d    = cpol_q;
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: directed and random transfers against a behavioural SPI slave model.
module tb_spi_master_gen;
    localparam int DW = 8;
    localparam int DV = 2;
    localparam int NC = 2;
    localparam int BUSY_CYC = (2 * DW + 2) * DV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic [0:0]    cs_sel = '0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          lsb_first = 1'b0;
    logic          miso = 1'b0;
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif
    logic          busy, done, sclk, mosi;
    logic [DW-1:0] rx_data;
    logic [NC-1:0] cs_n;

    int n_total = 0;
    int n_pass  = 0;

    // Slave model / monitor state
    logic [DW-1:0] s_word = '0;
    logic [DW-1:0] m_word = '0;
    logic          s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, s_mute = 1'b0;
    int            s_i = 0;
    logic          prev_sclk = 1'b0, prev_busy = 1'b0;
    int            busy_cnt = 0, done_cnt = 0, cs_bad = 0;
    logic [NC-1:0] cs_seen = '1, exp_cs = '1;
    logic          first_mosi = 1'b0;
    bit            first_got = 1'b0;

    spi_master_gen #(.DATA_W(DW), .DIV(DV), .NCS(NC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tx_data  (tx_data),
        .cs_sel   (cs_sel),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsb_first(lsb_first),
        .miso     (miso),
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
        .loopback (loopback),
`endif
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n)
    );

    always #5 clk = ~clk;

    function automatic int ord(input int i);
        return s_lsb ? i : (DW - 1 - i);
    endfunction

    // Slave behaves like a real SPI device: it watches sclk edges relative to its idle level.
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            s_i = 0;
            m_word = '0;
            first_got = 1'b0;
            cs_seen = cs_n;
            if (!s_cpha) miso = s_mute ? 1'b0 : s_word[ord(0)];
        end else if (busy && (sclk !== prev_sclk)) begin
            if (sclk !== s_cpol) begin
                if (!s_cpha) begin
                    if (s_i < DW) begin
                        m_word[ord(s_i)] = mosi;
                        if (!first_got) begin first_mosi = mosi; first_got = 1'b1; end
                    end
                end else if (s_i < DW) begin
                    miso = s_mute ? 1'b0 : s_word[ord(s_i)];
                end
            end else begin
                if (s_cpha && s_i < DW) begin
                    m_word[ord(s_i)] = mosi;
                    if (!first_got) begin first_mosi = mosi; first_got = 1'b1; end
                end
                s_i++;
                if (!s_cpha && s_i < DW) miso = s_mute ? 1'b0 : s_word[ord(s_i)];
            end
        end
        if (busy) begin
            busy_cnt++;
            if (cs_n !== exp_cs) cs_bad++;
        end
        if (done) done_cnt++;
        prev_busy = busy;
        prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic run_xfer(input string tag, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                            input logic pol, input logic pha, input logic lsb, input logic cs,
                            input bit restart);
        int cyc;
        logic [DW-1:0] exp_rx;
        s_word = sw; s_cpol = pol; s_cpha = pha; s_lsb = lsb;
        exp_cs = cs ? 2'b01 : 2'b10;
        exp_rx = s_mute ? tx : sw;
        busy_cnt = 0; done_cnt = 0; cs_bad = 0;
        tx_data = tx; cs_sel = cs; cpol = pol; cpha = pha; lsb_first = lsb; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 500) begin
            if (restart && cyc == 10) begin
                start = 1'b1; tx_data = ~tx; cpol = ~pol; cpha = ~pha; lsb_first = ~lsb; cs_sel = ~cs;
            end else if (cyc == 11) begin
                start = 1'b0; tx_data = tx; cpol = pol; cpha = pha; lsb_first = lsb; cs_sel = cs;
            end
            @(posedge clk); #2;
            cyc++;
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".rx"}, 32'(rx_data), 32'(exp_rx));
        repeat (4) @(posedge clk);
        #2;
        check({tag, ".rx_hold"}, 32'(rx_data), 32'(exp_rx));
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(BUSY_CYC));
        check({tag, ".done_count"}, 32'(done_cnt), 32'd1);
        check({tag, ".cs_sel"}, 32'(cs_seen), 32'(exp_cs));
        check({tag, ".cs_stable"}, 32'(cs_bad), 32'd0);
        check({tag, ".mosi_word"}, 32'(m_word), 32'(tx));
        check({tag, ".first_mosi"}, 32'(first_mosi), 32'(lsb ? tx[0] : tx[DW-1]));
        check({tag, ".idle_sclk"}, 32'(sclk), 32'(pol));
        check({tag, ".idle_mosi"}, 32'(mosi), 32'd0);
        check({tag, ".idle_cs"}, 32'(cs_n), 32'h3);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.cs_n", 32'(cs_n), 32'h3);
        check("reset.sclk", 32'(sclk), 32'd0);
        check("reset.mosi", 32'(mosi), 32'd0);
        check("reset.rx", 32'(rx_data), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Start offered in the very first cycle after reset release.
        run_xfer("basic", 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_xfer("mode3_lsb", 8'h01, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        run_xfer("restart", 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            run_xfer($sformatf("rand%0d", k), DW'($urandom), DW'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort mid-transfer with reset.
        s_word = 8'h99; s_cpol = 1'b1; s_cpha = 1'b0; s_lsb = 1'b0; exp_cs = 2'b10;
        tx_data = 8'h77; cs_sel = 1'b0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.cs_n", 32'(cs_n), 32'h3);
        check("abort.sclk", 32'(sclk), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.rx", 32'(rx_data), 32'd0);
        check("abort.mosi", 32'(mosi), 32'd0);
        @(posedge clk); #2;
        done_cnt = 0;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        check("abort.no_done", 32'(done_cnt), 32'd0);
        check("abort.idle_busy", 32'(busy), 32'd0);
        run_xfer("after_abort", 8'hC6, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
        s_mute = 1'b1;
        loopback = 1'b1;
        for (int m = 0; m < 4; m++) begin
            run_xfer($sformatf("loop_mode%0d", m), DW'($urandom), 8'hFF,
                     1'(m >> 1), 1'(m & 1), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        loopback = 1'b0;
        s_mute = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master_gen.md
SPI_MASTER_GEN -- requirements
Module: spi_master_gen

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: bits per transfer, legal range 2..32.
REQ-002 SHALL provide parameter DIV, default 4: SCLK half-period in clk cycles, legal range 1..255.
REQ-003 SHALL provide parameter NCS, default 2: number of chip selects; CSW = max(1, clog2(NCS)).
REQ-004 SHALL have ports, in this order:
  - clk  in  1  system clock; all logic on rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - start  in  1  request a transfer; accepted only when idle.
  - tx_data  in  DATA_W  word to send.
  - cs_sel  in  CSW  target chip select index.
  - cpol  in  1  SCLK idle level.
  - cpha  in  1  clock phase.
  - lsb_first  in  1  shift order: 1 = bit 0 first, 0 = bit DATA_W-1 first.
  - miso  in  1  serial data in.
  - busy  out  1  transfer in progress.
  - done  out  1  one-cycle completion pulse.
  - rx_data  out  DATA_W  last received word.
  - sclk  out  1  serial clock.
  - mosi  out  1  serial data out.
  - cs_n  out  NCS  active-low chip selects.

Function
REQ-005 SHALL use a single clk domain with no derived clocks; sclk is a register toggled by a DIV-cycle tick counter.
REQ-006 SHALL implement FSM states IDLE, SETUP, XFER and HOLD.
  - IDLE to SETUP on start=1.
  - SETUP to XFER after DIV cycles.
  - XFER to HOLD after 2*DATA_W sclk edges.
  - HOLD to IDLE after DIV cycles.
REQ-007 SHALL latch tx_data, cs_sel, cpol, cpha and lsb_first in the acceptance cycle; input changes during a transfer have no effect.
REQ-008 SHALL ignore start while busy=1; requests are not queued.
REQ-009 SHALL drive busy=1 from the cycle after acceptance through the last HOLD cycle, for exactly (2*DATA_W+2)*DIV cycles.
REQ-010 SHALL pulse done for one cycle in the first IDLE cycle after HOLD, and update rx_data in that same cycle.
REQ-011 SHALL hold rx_data stable until the next done.
REQ-012 SHALL drive cs_n[cs_sel] low during SETUP, XFER and HOLD, and drive all other cs_n bits high.
REQ-013 SHALL drive all cs_n bits high in IDLE; if cs_sel >= NCS, all cs_n bits stay high but the transfer still runs.
REQ-014 SHALL hold sclk at the latched cpol value in SETUP and HOLD, and at the registered cpol input in IDLE.
REQ-015 With cpha=0, SHALL present the first bit on mosi from SETUP entry, sample miso on each leading sclk edge, and shift mosi on each trailing edge except the last.
REQ-016 With cpha=1, SHALL shift mosi on each leading edge, with the first bit presented on the first leading edge, and sample miso on each trailing edge.
REQ-017 SHALL assemble received bits in the same order as transmitted bits, so a loop of mosi to miso returns tx_data unchanged.
REQ-018 SHALL drive mosi low in IDLE.

Reset
REQ-019 On rst_n=0, SHALL immediately force the following, regardless of FSM state (including mid-transfer): state=IDLE, busy=0, done=0, rx_data=0, sclk=0, mosi=0, cs_n all ones, and counters cleared.
REQ-020 SHALL not generate a done pulse for an aborted transfer after reset release.
REQ-021 SHALL accept start in the first clk edge after rst_n deasserts.

Configuration
REQ-022 With macro SPI_MASTER_GEN_LOOPBACK_EN defined, SHALL add an input port loopback (1 bit, after miso); when loopback=1, sampling SHALL use the internal mosi value instead of miso, and sclk and cs_n behave unchanged.
REQ-023 Without SPI_MASTER_GEN_LOOPBACK_EN, SHALL have no loopback port and always sample miso.

Verification
REQ-024 DATA_W=8, DIV=2, cpol=0, cpha=0, lsb_first=0, tx_data=0xA5, slave model returns 0x3C -> mosi carries 1,0,1,0,0,1,0,1; rx_data=0x3C; busy high 36 cycles; one done pulse; cs_n=2'b10.
REQ-025 Same setup with cpol=1, cpha=1, lsb_first=1, cs_sel=1, tx_data=0x01 -> sclk idles high; first mosi bit=1; cs_n=2'b01; rx_data equals the slave word LSB-first.
REQ-026 start pulsed again at cycle 10 of an active transfer with a different tx_data -> no change in the ongoing transfer and exactly one done.
REQ-027 rst_n low at cycle 15 of a transfer -> cs_n=all ones, sclk=0, busy=0 at once; rx_data=0; no done after release; next start completes normally.
REQ-028 SPI_MASTER_GEN_LOOPBACK_EN defined, loopback=1, DATA_W=16, tx_data=0xBEEF, miso tied 0 -> rx_data=0xBEEF in all four cpol/cpha modes.
